load_data_queue: RTL and testbench
==================================

LOAD_DATA_QUEUE -- requirements
Module: load_data_queue

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk_i  in  1  system clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 disp_vld_i  in  1  allocate one new load entry at tail this cycle.
REQ-005 disp_sdq_marker_i  in  $clog2(SDQ_ENTRIES)+1  store-queue tail marker (incl. wrap bit) captured with the load.
REQ-006 ldq_disp_idx_o  out  $clog2(LDQ_ENTRIES)  index the next dispatch will occupy (tail pointer).
REQ-007 ldq_full_o  out  1  all LDQ_ENTRIES entries occupied.
REQ-008 exec_vld_i  in  1  address-generation result valid.
REQ-009 exec_ldq_idx_i  in  $clog2(LDQ_ENTRIES)  target entry of the address result.
REQ-010 exec_addr_i  in  32  computed load address.
REQ-011 issue_en_i  in  1  downstream can accept a load this cycle.
REQ-012 issue_entry_o  out  ldq_entry_t  contents of the head entry.
REQ-013 issue_vld_o  out  1  head entry issues this cycle.

Function
REQ-014 SHALL be a circular queue of LDQ_ENTRIES entries with head and tail pointers plus an occupancy count of $clog2(LDQ_ENTRIES)+1 bits.
REQ-015 Entry fields: valid, addr_vld, addr[31:0], sdq_marker.
REQ-016 Dispatch: if disp_vld_i and not ldq_full_o, the next edge writes the entry at tail with valid=1, addr_vld=0, addr=0, sdq_marker=disp_sdq_marker_i, then increments tail modulo LDQ_ENTRIES.
REQ-017 Dispatch while ldq_full_o SHALL be ignored, with no state change.
REQ-018 ldq_full_o SHALL be combinational from registered count (count==LDQ_ENTRIES); a same-cycle issue does not free a slot for a same-cycle dispatch.
REQ-019 Exec: if exec_vld_i and the indexed entry is valid, the next edge sets addr=exec_addr_i and addr_vld=1.
REQ-020 Exec to an invalid entry SHALL be ignored.
REQ-021 A repeated exec to the same entry overwrites addr.
REQ-022 Issue is strictly in order from head: issue_vld_o = head.valid & head.addr_vld & issue_en_i (combinational, from registered state).
REQ-023 issue_entry_o SHALL always present the head entry, independent of issue_vld_o.
REQ-024 When issue_vld_o=1, the next edge clears head.valid and head.addr_vld and increments head modulo LDQ_ENTRIES.
REQ-025 An exec targeting the head in the same cycle is not bypassed; it issues no earlier than the next cycle.
REQ-026 Simultaneous dispatch and issue SHALL both take effect; count is unchanged.
REQ-027 Pointers wrap from LDQ_ENTRIES-1 to 0.
REQ-028 Dispatch and exec to different entries in the same cycle both take effect.

Reset
REQ-029 On rst_i, all entries become invalid (all fields 0), and head, tail and count are cleared to 0.
REQ-030 Reset outputs: ldq_disp_idx_o=0, ldq_full_o=0, issue_vld_o=0, issue_entry_o all zero.
REQ-031 Reset SHALL override dispatch, exec and issue in the same cycle, including mid-operation.

Structure
REQ-032 LDQ_ENTRIES (16), SDQ_ENTRIES and typedef ldq_entry_t (valid, addr_vld, addr, sdq_marker) SHALL live in CORE_PKG.
REQ-033 SHALL be a single flat module; no sub-modules.

Verification
REQ-034 Reset, then dispatch marker 5 -> ldq_disp_idx_o 0->1; issue_entry_o.valid=1, sdq_marker=5, addr_vld=0; issue_vld_o=0.
REQ-035 Exec idx 15 addr 5108 on an empty slot -> no change. Exec idx 0 addr 5108 with issue_en_i=1 -> next cycle issue_vld_o=1 with addr=5108; queue empty after.
REQ-036 After reset, 17 dispatches -> ldq_full_o=1 after the 16th, 17th ignored, ldq_disp_idx_o wraps to 0.
REQ-037 Exec idx i addr 3*i for i=0..15 with issue_en_i=1 -> 16 issues in order 0..15 with addresses 0,3,...,45; ldq_full_o drops after the first issue.
REQ-038 Exec idx 1 before idx 0 -> no issue until idx 0 has an address; then 0 issues, then 1. issue_en_i=0 holds issue.
REQ-039 Assert rst_i with 8 entries occupied -> all state and outputs cleared the next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core parameters and the load-queue entry layout.
// Marker width carries one extra wrap bit so store-queue age compares survive pointer wrap.
package core_pkg;

  localparam int LDQ_ENTRIES  = 16;
  localparam int SDQ_ENTRIES  = 16;
  localparam int LDQ_IDX_W    = $clog2(LDQ_ENTRIES);
  localparam int LDQ_CNT_W    = LDQ_IDX_W + 1;
  localparam int SDQ_MARKER_W = $clog2(SDQ_ENTRIES) + 1;

  localparam logic [LDQ_CNT_W-1:0] LDQ_FULL_CNT = LDQ_CNT_W'(LDQ_ENTRIES);

  typedef struct packed {
    logic                    valid;
    logic                    addr_vld;
    logic [31:0]             addr;
    logic [SDQ_MARKER_W-1:0] sdq_marker;
  } ldq_entry_t;

endpackage

// File: rtl/load_data_queue.sv
// Load data queue: in-order circular buffer of loads, filled at dispatch,
// completed by address generation, drained in order from the head.
module load_data_queue
  import core_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    disp_vld_i,
  input  logic [SDQ_MARKER_W-1:0] disp_sdq_marker_i,
  output logic [LDQ_IDX_W-1:0]    ldq_disp_idx_o,
  output logic                    ldq_full_o,
  input  logic                    exec_vld_i,
  input  logic [LDQ_IDX_W-1:0]    exec_ldq_idx_i,
  input  logic [31:0]             exec_addr_i,
  input  logic                    issue_en_i,
  output ldq_entry_t              issue_entry_o,
  output logic                    issue_vld_o
);

  ldq_entry_t           entries [LDQ_ENTRIES];
  logic [LDQ_IDX_W-1:0] head;
  logic [LDQ_IDX_W-1:0] tail;
  logic [LDQ_CNT_W-1:0] count;

  logic disp_ok;
  logic exec_ok;

  // Full is taken from the registered count, so an issue this cycle
  // cannot make room for a dispatch in the same cycle.
  assign ldq_full_o     = (count == LDQ_FULL_CNT);
  assign ldq_disp_idx_o = tail;
  assign issue_entry_o  = entries[head];
  assign issue_vld_o    = entries[head].valid & entries[head].addr_vld & issue_en_i;

  assign disp_ok = disp_vld_i & ~ldq_full_o;
  assign exec_ok = exec_vld_i & entries[exec_ldq_idx_i].valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LDQ_ENTRIES; i++) begin
        entries[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (exec_ok) begin
        entries[exec_ldq_idx_i].addr     <= exec_addr_i;
        entries[exec_ldq_idx_i].addr_vld <= 1'b1;
      end

      if (disp_ok) begin
        entries[tail].valid      <= 1'b1;
        entries[tail].addr_vld   <= 1'b0;
        entries[tail].addr       <= '0;
        entries[tail].sdq_marker <= disp_sdq_marker_i;
        tail                     <= tail + LDQ_IDX_W'(1);
      end

      // Issue clears last so a same-cycle exec to the departing head is dropped.
      if (issue_vld_o) begin
        entries[head].valid    <= 1'b0;
        entries[head].addr_vld <= 1'b0;
        head                   <= head + LDQ_IDX_W'(1);
      end

      case ({disp_ok, issue_vld_o})
        2'b10:   count <= count + LDQ_CNT_W'(1);
        2'b01:   count <= count - LDQ_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_load_data_queue.sv
// Self-checking bench for load_data_queue: directed scenarios followed by
// random traffic, compared every cycle against an ordered-queue reference model.
module tb_load_data_queue;
  import core_pkg::*;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    disp_vld_i;
  logic [SDQ_MARKER_W-1:0] disp_sdq_marker_i;
  logic [LDQ_IDX_W-1:0]    ldq_disp_idx_o;
  logic                    ldq_full_o;
  logic                    exec_vld_i;
  logic [LDQ_IDX_W-1:0]    exec_ldq_idx_i;
  logic [31:0]             exec_addr_i;
  logic                    issue_en_i;
  ldq_entry_t              issue_entry_o;
  logic                    issue_vld_o;

  int n_cmp = 0;
  int n_err = 0;

  load_data_queue dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .disp_vld_i        (disp_vld_i),
    .disp_sdq_marker_i (disp_sdq_marker_i),
    .ldq_disp_idx_o    (ldq_disp_idx_o),
    .ldq_full_o        (ldq_full_o),
    .exec_vld_i        (exec_vld_i),
    .exec_ldq_idx_i    (exec_ldq_idx_i),
    .exec_addr_i       (exec_addr_i),
    .issue_en_i        (issue_en_i),
    .issue_entry_o     (issue_entry_o),
    .issue_vld_o       (issue_vld_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: program-order list of occupied slots plus the last
  // values written into each slot (fields survive issue until overwritten).
  int   m_order[$];
  int   m_head;
  bit   m_avld  [LDQ_ENTRIES];
  int   m_addr  [LDQ_ENTRIES];
  int   m_marker[LDQ_ENTRIES];

  function automatic bit m_is_live(int slot);
    foreach (m_order[k]) if (m_order[k] == slot) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_reset();
    m_order.delete();
    m_head = 0;
    for (int i = 0; i < LDQ_ENTRIES; i++) begin
      m_avld[i] = 1'b0; m_addr[i] = 0; m_marker[i] = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance both.
  task automatic step(input bit rst, input bit d, input int mk,
                      input bit e, input int idx, input int a, input bit ie);
    bit         head_live, exp_iss, disp_ok, exec_ok;
    ldq_entry_t exp_entry;
    rst_i = rst; disp_vld_i = d; disp_sdq_marker_i = SDQ_MARKER_W'(mk);
    exec_vld_i = e; exec_ldq_idx_i = LDQ_IDX_W'(idx); exec_addr_i = a; issue_en_i = ie;
    #1;
    head_live = (m_order.size() > 0);
    exp_iss   = head_live && m_avld[m_head] && ie;
    exp_entry.valid      = head_live;
    exp_entry.addr_vld   = head_live && m_avld[m_head];
    exp_entry.addr       = m_addr[m_head];
    exp_entry.sdq_marker = SDQ_MARKER_W'(m_marker[m_head]);
    chk("disp_idx",    64'(ldq_disp_idx_o), 64'((m_head + m_order.size()) % LDQ_ENTRIES));
    chk("full",        64'(ldq_full_o),     64'(m_order.size() == LDQ_ENTRIES));
    chk("issue_vld",   64'(issue_vld_o),    64'(exp_iss));
    chk("issue_entry", 64'(issue_entry_o),  64'(exp_entry));

    if (rst) m_reset();
    else begin
      disp_ok = d && (m_order.size() < LDQ_ENTRIES);
      exec_ok = e && m_is_live(idx);
      if (exec_ok) begin m_addr[idx] = a; m_avld[idx] = 1'b1; end
      if (disp_ok) begin
        int t = (m_head + m_order.size()) % LDQ_ENTRIES;
        m_avld[t] = 1'b0; m_addr[t] = 0; m_marker[t] = mk;
        m_order.push_back(t);
      end
      if (exp_iss) begin
        m_avld[m_head] = 1'b0;
        void'(m_order.pop_front());
        m_head = (m_head + 1) % LDQ_ENTRIES;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input bit ie);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, ie);
  endtask

  initial begin
    m_reset();
    rst_i = 1'b1; disp_vld_i = 1'b0; disp_sdq_marker_i = '0;
    exec_vld_i = 1'b0; exec_ldq_idx_i = '0; exec_addr_i = '0; issue_en_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);

    // Single dispatch, exec to empty slot ignored, exec then issue.
    step(1'b0, 1'b1, 5, 1'b0, 0, 0, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 15, 5108, 1'b1);
    idle(1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 0, 5108, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill to full with one extra dispatch, then drain in order.
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, i, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 0, 1'b1, i, 3 * i, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Out-of-order address completion and issue_en hold.
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1, 77, 1'b1);
    idle(1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 0, 66, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Reset mid-operation with traffic on every input.
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i + 3, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 0, 123, 1'b0);
    step(1'b1, 1'b1, 9, 1'b1, 1, 456, 1'b1);
    idle(1'b1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit rst, d, e, ie;
      int idx;
      rst = ($urandom_range(0, 299) == 0);
      d   = ($urandom_range(0, 99) < 55);
      e   = ($urandom_range(0, 99) < 60);
      ie  = ($urandom_range(0, 99) < 65);
      if (m_order.size() > 0 && $urandom_range(0, 3) != 0)
        idx = m_order[$urandom_range(0, m_order.size() - 1)];
      else
        idx = $urandom_range(0, LDQ_ENTRIES - 1);
      step(rst, d, $urandom_range(0, (1 << SDQ_MARKER_W) - 1), e, idx, $urandom, ie);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
